wptr_full: RTL and testbench

Write-side pointer and full-flag controller for the asynchronous FIFO, running entirely in the write clock domain. It accepts write requests, drives the dual-port RAM write enable and address, and keeps the binary and Gray write pointers. The Gray write pointer is exported to the read-domain synchronizer. The block also brings the read-domain Gray read pointer in through its own 2-flop synchronizer and uses it to generate full, almost-full, occupancy and overflow status.

---
 rtl/wptr_full.sv | 100 ++++++++++
 tb/tb_wptr_full.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full.sv
// wptr_full: write-domain pointer, RAM write port and full/level status for an async FIFO.
// Latency: an accepted write shows in wptr_g/waddr/wlevel/wfull at the same edge; rptr_g reaches status on the 3rd edge.
// Backpressure: wen is winc gated by the registered wfull; winc while full is dropped and latched in woverflow.
// Ports: wclk/wrst_n clock and async active-low reset; winc write request; rptr_g Gray read pointer (async);
//        wptr_g Gray write pointer to read side; waddr/wen RAM write port; wfull/walmost_full/wlevel status;
//        woverflow sticky write-while-full flag.
module wptr_full #(
  parameter int ptr_width   = 11,
  parameter int afull_level = 4
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 winc,
  input  logic [ptr_width-1:0] rptr_g,
  output logic [ptr_width-1:0] wptr_g,
  output logic [ptr_width-2:0] waddr,
  output logic                 wen,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ptr_width-1:0] wlevel,
  output logic                 woverflow
);

  localparam int AW = ptr_width - 1;
  localparam logic [ptr_width-1:0] DEPTH     = {1'b1, {AW{1'b0}}};
  localparam logic [ptr_width-1:0] AFULL_THR = DEPTH - ptr_width'(afull_level);

  logic [ptr_width-1:0] r_wbin;
  logic [ptr_width-1:0] r_wptr_g;
  logic [ptr_width-1:0] r_wq1_rptr;
  logic [ptr_width-1:0] r_wq2_rptr;
  logic                 r_wfull;
  logic                 r_walmost_full;
  logic [ptr_width-1:0] r_wlevel;
  logic                 r_woverflow;

  logic                 w_wen;
  logic [ptr_width-1:0] w_wbin_next;
  logic [ptr_width-1:0] w_wgray_next;
  logic [ptr_width-1:0] w_full_cmp;
  logic [ptr_width-1:0] w_rbin_s;
  logic [ptr_width-1:0] w_wlevel_next;

  // Gated by wrst_n so a stray winc during reset can never reach the RAM.
  assign w_wen        = winc & ~r_wfull & wrst_n;
  assign w_wbin_next  = r_wbin + {{AW{1'b0}}, w_wen};
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

  // Full when the write pointer is exactly one lap ahead: in Gray code that is
  // the read pointer with its two top bits inverted.
  assign w_full_cmp = {~r_wq2_rptr[ptr_width-1:ptr_width-2], r_wq2_rptr[ptr_width-3:0]};

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rbin_s = '0;
    for (int i = 0; i < ptr_width; i++) begin
      w_rbin_s[i] = ^(r_wq2_rptr >> i);
    end
  end

  assign w_wlevel_next = w_wbin_next - w_rbin_s;

  // Plain two-flop synchronizer; nothing may be inserted between the stages.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wq1_rptr <= '0;
      r_wq2_rptr <= '0;
    end else begin
      r_wq1_rptr <= rptr_g;
      r_wq2_rptr <= r_wq1_rptr;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin         <= '0;
      r_wptr_g       <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wlevel       <= '0;
      r_woverflow    <= 1'b0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_wptr_g       <= w_wgray_next;
      r_wfull        <= (w_wgray_next == w_full_cmp);
      r_walmost_full <= (w_wlevel_next >= AFULL_THR);
      r_wlevel       <= w_wlevel_next;
      r_woverflow    <= r_woverflow | (winc & r_wfull);
    end
  end

  assign wen          = w_wen;
  assign wptr_g       = r_wptr_g;
  assign waddr        = r_wbin[AW-1:0];
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wlevel       = r_wlevel;
  assign woverflow    = r_woverflow;

endmodule

// File: tb/tb_wptr_full.sv
module tb_wptr_full;

  localparam int PW = 11;
  localparam int D  = 1 << (PW - 1);
  localparam int AF = 4;

  logic          wclk   = 1'b0;
  logic          wrst_n = 1'b1;
  logic          winc   = 1'b0;
  logic [PW-1:0] rptr_g = '0;
  logic [PW-1:0] wptr_g;
  logic [PW-2:0] waddr;
  logic          wen;
  logic          wfull;
  logic          walmost_full;
  logic [PW-1:0] wlevel;
  logic          woverflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain counts of accepted writes and performed reads.
  // rq holds the read count sampled at the last three edges; rq[0] is the
  // value the write side has seen after crossing the synchronizer.
  int wr_cnt;
  int rd_cnt;
  int rq[$];
  bit full_m;
  bit ovf_m;
  bit acc_m;

  always #5 wclk = ~wclk;

  wptr_full #(.ptr_width(PW), .afull_level(AF)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .rptr_g       (rptr_g),
    .wptr_g       (wptr_g),
    .waddr        (waddr),
    .wen          (wen),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    wr_cnt = 0;
    rd_cnt = 0;
    rq     = '{0, 0, 0};
    full_m = 1'b0;
    ovf_m  = 1'b0;
  endtask

  task automatic set_rd(input int v);
    rd_cnt = v;
    rptr_g = gray(v);
  endtask

  task automatic check_state();
    int lvl;
    lvl = wr_cnt - rq[0];
    chk("wptr_g",       wptr_g,       gray(wr_cnt));
    chk("waddr",        waddr,        wr_cnt % D);
    chk("wlevel",       wlevel,       lvl);
    chk("wfull",        wfull,        lvl == D);
    chk("walmost_full", walmost_full, lvl >= D - AF);
    chk("woverflow",    woverflow,    ovf_m);
  endtask

  // One clock: check wen for the current inputs, advance model on the edge,
  // then compare every registered output just after it.
  task automatic step();
    logic [PW-1:0] prev;
    #1;
    chk("wen", wen, winc && !full_m);
    prev = wptr_g;
    @(posedge wclk);
    acc_m = winc && !full_m;
    if (winc && full_m) ovf_m = 1'b1;
    if (acc_m) wr_cnt++;
    rq.push_back(rd_cnt);
    void'(rq.pop_front());
    full_m = ((wr_cnt - rq[0]) == D);
    #1;
    check_state();
    chk("gray_step", $countones(wptr_g ^ prev), acc_m ? 1 : 0);
  endtask

  initial begin
    int wh[$];
    int wraps;
    int p_rd;
    bit full_seen;

    model_reset();
    set_rd(0);
    #1 wrst_n = 1'b0;
    #1;
    chk("rst_wptr_g", wptr_g, 0);
    chk("rst_waddr",  waddr,  0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_wfull",  wfull,  0);
    chk("rst_afull",  walmost_full, 0);
    chk("rst_ovf",    woverflow, 0);
    chk("rst_wen",    wen, 0);
    repeat (3) @(posedge wclk);
    #1 wrst_n = 1'b1;

    // Fill from empty with the read pointer parked at 0.
    winc = 1'b1;
    for (int i = 1; i <= D; i++) begin
      step();
      if (i == D - AF - 1) chk("afull_1019", walmost_full, 0);
      if (i == D - AF)     chk("afull_1020", walmost_full, 1);
    end
    chk("fill_wfull",  wfull,  1);
    chk("fill_wptr_g", wptr_g, 11'h600);
    chk("fill_waddr",  waddr,  0);
    chk("fill_wlevel", wlevel, D);

    // Writes while full are dropped and latch the overflow flag.
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) chk("ovf_set", woverflow, 1);
    end
    chk("ovf_wptr_hold", wptr_g, 11'h600);

    // Drain: read pointer jumps to 512, seen on the 3rd edge.
    winc = 1'b0;
    set_rd(512);
    step();
    chk("drain_e1_full",  wfull,  1);
    chk("drain_e1_level", wlevel, D);
    step();
    chk("drain_e2_full",  wfull,  1);
    chk("drain_e2_level", wlevel, D);
    step();
    chk("drain_e3_full",  wfull,  0);
    chk("drain_e3_level", wlevel, 512);

    // Wrap: continuous writes, read pointer trailing by 3 cycles.
    winc      = 1'b1;
    wraps     = 0;
    full_seen = 1'b0;
    wh        = '{wr_cnt, wr_cnt, wr_cnt};
    for (int i = 0; i < 5000; i++) begin
      step();
      if (wptr_g == '0) wraps++;
      if (wfull) full_seen = 1'b1;
      wh.push_back(wr_cnt);
      set_rd(wh.pop_front());
    end
    chk("wrap_count",  wraps >= 2, 1);
    chk("wrap_nofull", full_seen, 0);
    chk("ovf_sticky",  woverflow, 1);

    // Reset in mid-stream with winc still high.
    #3 wrst_n = 1'b0;
    #1;
    chk("mrst_wptr_g", wptr_g, 0);
    chk("mrst_waddr",  waddr,  0);
    chk("mrst_wlevel", wlevel, 0);
    chk("mrst_wfull",  wfull,  0);
    chk("mrst_afull",  walmost_full, 0);
    chk("mrst_ovf",    woverflow, 0);
    chk("mrst_wen",    wen, 0);
    model_reset();
    set_rd(0);
    repeat (2) @(posedge wclk);
    #1;
    chk("mrst_wen_hold", wen, 0);
    wrst_n = 1'b1;
    #1;
    chk("post_rst_wen",   wen,   1);
    chk("post_rst_waddr", waddr, 0);

    // Random traffic: slow reader first (reaches full), then fast reader.
    for (int i = 0; i < 5000; i++) begin
      if (i < 3000) begin
        winc = ($urandom % 4) != 0;
        p_rd = 20;
      end else begin
        winc = ($urandom % 2) != 0;
        p_rd = 95;
      end
      if (rd_cnt < wr_cnt && ($urandom % 100) < p_rd) set_rd(rd_cnt + 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
